// File: rtl/not_check_monitor.sv
// Response-side checker for the bitwise-NOT unit: tallies result == ~operand over a
// valid/ready stream and reports an integer pass percentage via a serial divider.
module not_check_monitor #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             finish,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] correct,
    output logic [6:0]       percent,
    output logic             fail_seen,
    output logic [WIDTH-1:0] first_fail
);

    localparam int NUM_W = CNT_W + 7;
    localparam int DC_W  = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   correct_q, correct_d;
    logic [6:0]         percent_q, percent_d;
    logic               fail_q, fail_d;
    logic [WIDTH-1:0]   first_fail_q, first_fail_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [6:0]         quo_q, quo_d;
    logic [DC_W-1:0]    div_cnt_q, div_cnt_d;

    logic               beat;
    logic               match;
    logic               div_last;
    logic [CNT_W:0]     rem_sh;
    logic [CNT_W:0]     rem_sub;
    logic               rem_ge;

    assign beat     = in_valid & in_ready_q;
    assign match    = (result == ~operand);
    assign div_last = (div_cnt_q == DC_W'(NUM_W - 1));

    // One restoring-division step: shift in the next numerator bit, subtract if it fits.
    assign rem_sh  = {rem_q, num_q[NUM_W-1]};
    assign rem_sub = rem_sh - {1'b0, count_q};
    assign rem_ge  = (rem_sh >= {1'b0, count_q});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN:   if (finish) state_d = S_DIV;
                S_DIV:   if (count_q == '0 || div_last) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DIV);
        done = (state_q == S_DONE);
    end

    always_comb begin
        in_ready_d   = (state_d == S_RUN);
        count_d      = count_q;
        correct_d    = correct_q;
        percent_d    = percent_q;
        fail_d       = fail_q;
        first_fail_d = first_fail_q;
        num_d        = num_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        div_cnt_d    = div_cnt_q;
        if (start) begin
            count_d      = '0;
            correct_d    = '0;
            percent_d    = '0;
            fail_d       = 1'b0;
            first_fail_d = '0;
            num_d        = '0;
            rem_d        = '0;
            quo_d        = '0;
            div_cnt_d    = '0;
        end else begin
            // Saturated beats still record the first mismatch.
            if (beat) begin
                if (count_q != '1) count_d = count_q + CNT_W'(1);
                if (match) begin
                    if (correct_q != '1) correct_d = correct_q + CNT_W'(1);
                end else if (!fail_q) begin
                    fail_d       = 1'b1;
                    first_fail_d = operand;
                end
            end
            if (state_q == S_RUN && finish) begin
                num_d     = NUM_W'(correct_d) * NUM_W'(100);
                rem_d     = '0;
                quo_d     = '0;
                div_cnt_d = '0;
            end
            if (state_q == S_DIV) begin
                if (count_q == '0) begin
                    percent_d = '0;
                end else begin
                    rem_d     = rem_ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                    num_d     = num_q << 1;
                    quo_d     = {quo_q[5:0], rem_ge};
                    div_cnt_d = div_cnt_q + DC_W'(1);
                    if (div_last) percent_d = quo_d;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q   <= 1'b0;
            count_q      <= '0;
            correct_q    <= '0;
            percent_q    <= '0;
            fail_q       <= 1'b0;
            first_fail_q <= '0;
            num_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            div_cnt_q    <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            count_q      <= count_d;
            correct_q    <= correct_d;
            percent_q    <= percent_d;
            fail_q       <= fail_d;
            first_fail_q <= first_fail_d;
            num_q        <= num_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            div_cnt_q    <= div_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign count      = count_q;
    assign correct    = correct_q;
    assign percent    = percent_q;
    assign fail_seen  = fail_q;
    assign first_fail = first_fail_q;

endmodule
